muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Control sequencer for the shared multiply/divide unit. It accepts a start request
// from main control while idle. It then enables the selected unit and waits for that
// unit's completion flag, with a bounded number of run cycles. On success it writes
// Hi/Lo for one cycle and pulses done. A divide by zero or an expired run budget
// pulses the matching exception instead, and Hi/Lo are left untouched.
//
// Parameters
//   TIMEOUT       maximum run cycles before the unit is aborted (legal 2..255)
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous reset, active low
//   start_mult    run MULT on the current rs/rt (wins over start_div)
//   start_div     run DIV on the current rs/rt
//   rt_zero       divisor is zero; only looked at together with start_div
//   fimDoMult     multiplier completion flag
//   fimDoDiv      divider completion flag
//   controleMult  multiplier run enable
//   DIV           divider run enable
//   MULT          Hi/Lo source select (1 = multiplier, 0 = divider)
//   HiWrite       Hi register write enable
//   LoWrite       Lo register write enable
//   busy          operation in progress, main control must stall
//   done          one-cycle pulse, Hi/Lo hold the new result
//   div_zero      one-cycle pulse, divide-by-zero exception
//   timeout       one-cycle pulse, unit did not finish within TIMEOUT run cycles

module muldiv_sequencer #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    input  logic rt_zero,
    input  logic fimDoMult,
    input  logic fimDoDiv,
    output logic controleMult,
    output logic DIV,
    output logic MULT,
    output logic HiWrite,
    output logic LoWrite,
    output logic busy,
    output logic done,
    output logic div_zero,
    output logic timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StMultRun,
        StDivRun,
        StWrite,
        StDone,
        StErr
    } state_e;

    // Counter value seen in the last allowed run cycle.
    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cause_dz_q, cause_dz_d;  // 1 = divide by zero, 0 = timeout
    logic       mult_q, mult_d;          // Hi/Lo mux select, held between operations

    logic       run_expired;
    logic [7:0] cnt_inc;

    assign run_expired = (cnt_q == LastCnt);
    // Saturating increment so the counter can never wrap back under the limit.
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            cause_dz_q <= 1'b0;
            mult_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_dz_q <= cause_dz_d;
            mult_q     <= mult_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_dz_d = cause_dz_q;
        mult_d     = mult_q;

        unique case (state_q)
            StIdle: begin
                if (start_mult) begin
                    state_d = StMultRun;
                    mult_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else if (start_div) begin
                    if (rt_zero) begin
                        // The divider is never started and MULT keeps its value.
                        state_d    = StErr;
                        cause_dz_d = 1'b1;
                    end else begin
                        state_d = StDivRun;
                        mult_d  = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end
            end

            StMultRun: begin
                // A flag in the last allowed cycle still counts as success.
                if (fimDoMult) begin
                    state_d = StWrite;
                end else if (run_expired) begin
                    state_d    = StErr;
                    cause_dz_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StDivRun: begin
                if (fimDoDiv) begin
                    state_d = StWrite;
                end else if (run_expired) begin
                    state_d    = StErr;
                    cause_dz_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign controleMult = (state_q == StMultRun);
    assign DIV          = (state_q == StDivRun);
    assign MULT         = mult_q;
    assign HiWrite      = (state_q == StWrite);
    assign LoWrite      = (state_q == StWrite);
    assign done         = (state_q == StDone);
    assign div_zero     = (state_q == StErr) &&  cause_dz_q;
    assign timeout      = (state_q == StErr) && !cause_dz_q;
    assign busy         = (state_q == StMultRun) || (state_q == StDivRun) ||
                          (state_q == StWrite)   || (state_q == StErr);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. Each operation's expected output trace is
// derived from its outcome: the run length N is the smaller of the flag cycle and
// TIMEOUT, followed by write/done or a single error cycle.
module tb_muldiv_sequencer;

    localparam int unsigned TO = 8;
    localparam bit O = 1'b0;
    localparam bit I = 1'b1;

    logic clk = 1'b0;
    logic reset, start_mult, start_div, rt_zero, fimDoMult, fimDoDiv;
    logic controleMult, DIV, MULT, HiWrite, LoWrite, busy, done, div_zero, timeout;
    logic [8:0] obs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mult_model = 1'b0;  // last Hi/Lo source selected, 0 after reset

    muldiv_sequencer #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .rt_zero     (rt_zero),
        .fimDoMult   (fimDoMult),
        .fimDoDiv    (fimDoDiv),
        .controleMult(controleMult),
        .DIV         (DIV),
        .MULT        (MULT),
        .HiWrite     (HiWrite),
        .LoWrite     (LoWrite),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {controleMult, DIV, MULT, HiWrite, LoWrite, busy, done, div_zero, timeout};

    // Expected output vector, same bit order as obs.
    function automatic logic [8:0] ev(input bit cm, input bit dv, input bit m, input bit wr,
                                      input bit bz, input bit dn, input bit dz, input bit tmo);
        return {cm, dv, m, wr, wr, bz, dn, dz, tmo};
    endfunction

    function automatic bit nz(input int noise);
        if (noise == 1) return 1'b1;
        if (noise == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: outputs %b, required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_mult = 1'b0;
        start_div  = 1'b0;
        rt_zero    = 1'b0;
        fimDoMult  = 1'b0;
        fimDoDiv   = 1'b0;
    endtask

    // One complete operation starting from IDLE. flag_at is the run cycle (1-based) in
    // which the selected unit's flag is raised; beyond TO it never arrives.
    task automatic do_op(input bit is_mult, input bit both, input bit rtz, input int flag_at,
                         input int noise, input bit hold_done, input string tag);
        int  n_run;
        bit  to_hit;
        bit  dz;
        int  t0;
        dz     = !is_mult && rtz;
        to_hit = (flag_at > int'(TO));
        n_run  = to_hit ? int'(TO) : flag_at;

        chk({tag, "/idle"}, ev(O, O, mult_model, O, O, O, O, O));
        start_mult = is_mult;
        start_div  = !is_mult || both;
        rt_zero    = rtz;
        step();
        t0 = cyc;
        clear_inputs();

        if (dz) begin
            chk({tag, "/err_dz"}, ev(O, O, mult_model, O, I, O, I, O));
            step();
            chk({tag, "/idle_after_dz"}, ev(O, O, mult_model, O, O, O, O, O));
            return;
        end

        mult_model = is_mult;
        for (int i = 1; i <= n_run; i++) begin
            chk({tag, "/run"}, ev(is_mult, !is_mult, is_mult, O, I, O, O, O));
            fimDoMult  = is_mult  ? (i == flag_at) : nz(noise);
            fimDoDiv   = !is_mult ? (i == flag_at) : nz(noise);
            start_mult = nz(noise);
            start_div  = nz(noise);
            rt_zero    = nz(noise);
            step();
        end
        clear_inputs();

        if (to_hit) begin
            chk({tag, "/err_timeout"}, ev(O, O, is_mult, O, I, O, O, I));
            step();
            chk({tag, "/idle_after_timeout"}, ev(O, O, is_mult, O, O, O, O, O));
            return;
        end

        chk({tag, "/write"}, ev(O, O, is_mult, I, I, O, O, O));
        step();
        chk({tag, "/done"}, ev(O, O, is_mult, O, O, I, O, O));
        // done occupies the (N+2)th cycle after the sampling edge
        chk_int({tag, "/latency"}, cyc - t0 + 1, n_run + 2);
        if (hold_done) start_mult = 1'b1;
        step();
        chk({tag, "/idle_after_done"}, ev(O, O, is_mult, O, O, O, O, O));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("reset_state", 9'b0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Multiply, flag in 5th run cycle: 5 run cycles, write, done.
        do_op(I, O, O, 5, 0, O, "mult_flag5");
        // Divide by zero: straight to ERR, divider never enabled.
        do_op(O, O, I, 1, 0, O, "div_zero");
        // Divide with no flag: TO run cycles then timeout.
        do_op(O, O, O, 100, 0, O, "div_timeout");
        // Flag in the very last allowed cycle still wins.
        do_op(O, O, O, TO, 0, O, "div_flag_last");
        // Both starts: multiply wins.
        do_op(I, I, O, 3, 0, O, "both_starts");
        // Foreign flag and extra starts asserted throughout a run are ignored.
        do_op(I, O, O, 4, 1, O, "mult_noise");
        do_op(O, O, O, 2, 1, O, "div_noise");
        // Start held during DONE is only taken in the following IDLE cycle.
        do_op(O, O, O, 1, 0, I, "hold_in_done");
        do_op(I, O, O, 1, 0, O, "after_hold");

        // Reset in the 3rd divide run cycle.
        chk("rst/idle", ev(O, O, mult_model, O, O, O, O, O));
        start_div = 1'b1;
        step();
        start_div  = 1'b0;
        mult_model = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("rst/div_run", ev(O, I, O, O, I, O, O, O));
            if (i < 3) step();
        end
        fimDoDiv = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("rst/async_clear", 9'b0);
        step();
        chk("rst/held", 9'b0);
        @(negedge clk);
        chk("rst/no_write", 9'b0);
        reset      = 1'b1;
        fimDoDiv   = 1'b0;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        mult_model = 1'b1;
        chk("rst/mult_accepted", ev(I, O, I, O, I, O, O, O));
        fimDoMult = 1'b1;
        step();
        fimDoMult = 1'b0;
        chk("rst/write", ev(O, O, I, I, I, O, O, O));
        step();
        chk("rst/done", ev(O, O, I, O, O, I, O, O));
        step();

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            bit m;
            bit b;
            bit z;
            m = 1'($urandom_range(0, 1));
            b = m & 1'($urandom_range(0, 1));
            z = ($urandom_range(0, 3) == 0);
            do_op(m, b, z, int'($urandom_range(1, TO + 2)), 2, 1'($urandom_range(0, 1)), "rand");
            start_mult = 1'b0;
            if (!m && z) chk("rand/settle", ev(O, O, mult_model, O, O, O, O, O));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
